// File: rtl/bus_share_arbiter_pkg.sv
// Shared definitions for the two-requester bus-share arbiter:
// FSM state encodings, owner codes and the hold counter width helper.
package bus_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IS_A = 1'b0,
    OWN_IS_B = 1'b1
  } owner_t;

  // Hold counter needs to reach MAX_HOLD-1 without wrapping.
  function automatic int hold_cw(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/bus_share_arbiter_hold_timer.sv
// Saturating up-counter tracking how long the current owner has held the bus.
// expired is high once the count has reached MAX_HOLD-1.
module bus_share_arbiter_hold_timer #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = $clog2(MAX_HOLD) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] count_q;

  // Clear wins over counting; the count stops at LAST instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit bus P between
// requesters A and B, with a bounded hold time under contention.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  ST_IDLE  | nobody owns the bus, waiting for a request
//  ST_OWN_A | A owns the bus, sel steers data_a onto P
//  ST_OWN_B | B owns the bus, sel steers data_b onto P
module bus_share_arbiter
  import bus_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] P,
  output logic             p_valid
);

  localparam int CW = hold_cw(MAX_HOLD);

  arb_state_t state_q;
  arb_state_t state_d;
  owner_t     last_owner_q;
  logic       hold_expired;
  logic       timer_clear;
  logic       timer_enable;

  // The counter restarts on every entry into an owning state and sits at zero in IDLE.
  assign timer_clear  = (state_q == ST_IDLE) || (state_d != state_q);
  assign timer_enable = (state_q == ST_OWN_A) || (state_q == ST_OWN_B);

  bus_share_arbiter_hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (hold_expired)
  );

  // State register; last_owner remembers who left an owning state most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_IS_B;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_OWN_A) && (state_d != ST_OWN_A)) begin
        last_owner_q <= OWN_IS_A;
      end else if ((state_q == ST_OWN_B) && (state_d != ST_OWN_B)) begin
        last_owner_q <= OWN_IS_B;
      end
    end
  end

  // Next-state logic: release first, then forced rotation once the hold time is used up.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = (last_owner_q == OWN_IS_A) ? ST_OWN_B : ST_OWN_A;
        end else if (req_a) begin
          state_d = ST_OWN_A;
        end else if (req_b) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!req_a && req_b) begin
          state_d = ST_OWN_B;
        end else if (!req_a) begin
          state_d = ST_IDLE;
        end else if (req_b && hold_expired) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!req_b && req_a) begin
          state_d = ST_OWN_A;
        end else if (!req_b) begin
          state_d = ST_IDLE;
        end else if (req_a && hold_expired) begin
          state_d = ST_OWN_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants and mux select decode straight from the state register, so they can never overlap.
  always_comb begin
    gnt_a = (state_q == ST_OWN_A);
    gnt_b = (state_q == ST_OWN_B);
    sel   = (state_q == ST_OWN_A);
  end

  // Capture the owner's word only while it still requests; otherwise P holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      P       <= '0;
      p_valid <= 1'b0;
    end else if ((state_q == ST_OWN_A) && req_a) begin
      P       <= data_a;
      p_valid <= 1'b1;
    end else if ((state_q == ST_OWN_B) && req_b) begin
      P       <= data_b;
      p_valid <= 1'b1;
    end else begin
      p_valid <= 1'b0;
    end
  end

endmodule
